vehicle_data_receiver: RTL and testbench
========================================

# vehicle_data_receiver

Receive-side counterpart of the vehicle data generator. Consumes CAN frames delivered by the CAN controller's receive AXI4-Stream, decodes the engine-revolution frame (ID 0x3D9) and the vehicle-speed frame (ID 0x3E9), and presents the latest values with per-signal freshness tracking. Feeds the dashboard/display logic, which must distinguish "no data yet", "fresh" and "stale" values.

## Interface
- TIMEOUT_CYCLE, 100_000_000: cycles without a valid update before a signal is declared stale (≥2)
- ID_ENGINE_REV, 11'h3D9: CAN ID of the engine-revolution frame
- ID_CAR_SPEED, 11'h3E9: CAN ID of the vehicle-speed frame

Ports:
- clk  in  1  clock; one clock domain
- rst  in  1  reset, synchronous, active-high
- stm_recv_data_in_tdata  in  64  received frame payload
- stm_recv_data_in_tid  in  11  received CAN ID
- stm_recv_data_in_tkeep  in  8  received byte enables
- stm_recv_data_in_tvalid  in  1  frame valid
- stm_recv_data_in_tready  out  1  accept
- engine_rev  out  14  last accepted engine revolution
- vehicle_speed  out  9  last accepted vehicle speed
- engine_rev_valid  out  1  engine_rev is FRESH
- vehicle_speed_valid  out  1  vehicle_speed is FRESH
- engine_rev_update  out  1  one-cycle pulse on engine_rev update
- vehicle_speed_update  out  1  one-cycle pulse on vehicle_speed update
- format_err_count  out  8  saturating count of rejected known-ID frames
- unknown_id_count  out  8  saturating count of frames with other IDs

## Operation
- tready: registered; 0 while rst is high and in the first cycle after rst is released, 1 thereafter. Accept occurs when tvalid & tready.
- Stage 1 (capture): on accept, register tdata, tid, tkeep and a capture-valid bit.
- Stage 2 (decode), on capture-valid:
  - tid == ID_ENGINE_REV: accept when tkeep == 8'hFF and tdata[7:0] == 8'hFF; engine_rev <= tdata[47:34]; otherwise format error.
  - tid == ID_CAR_SPEED: accept when tkeep == 8'hFF; vehicle_speed <= tdata[63:55]; otherwise format error.
  - Any other ID: unknown_id_count increments; outputs are untouched.
  - All remaining tdata bits are ignored.
- Counters saturate at 8'hFF and never wrap.
- Per-signal freshness FSM, one instance each for engine rev and speed:
  - States: NO_DATA, FRESH, STALE.
  - NO_DATA -> FRESH on a valid update.
  - FRESH -> STALE when the age counter reaches TIMEOUT_CYCLE-1.
  - STALE -> FRESH on a valid update.
  - The age counter clears on every valid update, increments in FRESH, and is held in NO_DATA and STALE.
  - *_valid = (state == FRESH). The value is held unchanged in STALE.
- Simultaneous update and timeout in the same cycle: the update wins (FRESH, age 0, valid stays 1).
- A rejected frame does not affect the age counter or the FSM.

## Timing
- Reset values: tready 0; engine_rev 0; vehicle_speed 0; all valid and update outputs 0; both counters 0; both FSMs NO_DATA; age counters 0; capture-valid 0.
- Handshake in cycle N: the new value, the update pulse and valid = 1 all appear in cycle N+2. Error and unknown counters change in cycle N+2.
- Back-to-back frames are accepted every cycle (fully pipelined, no backpressure after reset).
- With the last update in cycle U, valid drops in cycle U+TIMEOUT_CYCLE.
- rst asserted mid-operation: the frame in flight in stage 1 or stage 2 is discarded. Every output returns to its reset value on the next edge.

## Test plan
- Reset release → tready 0 in the first cycle after release, 1 from the second; all outputs 0; both valids 0.
- Frame ID 0x3D9, tkeep FF, engine_rev 14'd8000 in tdata[47:34], byte0 FF → in cycle N+2, engine_rev = 8000, engine_rev_valid = 1, one-cycle engine_rev_update.
- Frame ID 0x3E9, tkeep FF, tdata[63:55] = 9'd300; the same frame is sent again back-to-back with 9'd301 → vehicle_speed = 300, then 301 on consecutive cycles; two update pulses.
- Rejected frames, sent one per cycle: ID 0x3D9 with byte0 = 00; ID 0x3E9 with tkeep = 0F; ID 0x123 → outputs unchanged; format_err_count = 2; unknown_id_count = 1. Then 300 unknown-ID frames → unknown_id_count saturates at 255.
- TIMEOUT_CYCLE = 16: one speed update, then idle → vehicle_speed_valid falls exactly 16 cycles after the update and the value is held. A new speed frame timed so its stage-2 decode lands in the timeout cycle → valid never drops and age restarts.
- rst asserted in the cycle after a handshake → no update pulse; all outputs read 0 after the reset edge; the next frame decodes normally.

Source files
------------

// File: rtl/vehicle_data_receiver.sv
// vehicle_data_receiver: decodes engine-rev and vehicle-speed CAN frames and tracks per-signal freshness
module vehicle_data_receiver #(
    parameter int          TIMEOUT_CYCLE = 100_000_000,
    parameter logic [10:0] ID_ENGINE_REV = 11'h3D9,
    parameter logic [10:0] ID_CAR_SPEED  = 11'h3E9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] stm_recv_data_in_tdata,
    input  logic [10:0] stm_recv_data_in_tid,
    input  logic [7:0]  stm_recv_data_in_tkeep,
    input  logic        stm_recv_data_in_tvalid,
    output logic        stm_recv_data_in_tready,
    output logic [13:0] engine_rev,
    output logic [8:0]  vehicle_speed,
    output logic        engine_rev_valid,
    output logic        vehicle_speed_valid,
    output logic        engine_rev_update,
    output logic        vehicle_speed_update,
    output logic [7:0]  format_err_count,
    output logic [7:0]  unknown_id_count
);
    localparam int AW = $clog2(TIMEOUT_CYCLE);
    localparam logic [AW-1:0] AGE_LAST = AW'(TIMEOUT_CYCLE - 1);

    typedef enum logic [1:0] {NO_DATA, FRESH, STALE} state_t;

    logic        r_tready;
    logic        r_cap_valid;
    logic [10:0] r_cap_id;
    logic [7:0]  r_cap_keep;
    logic [7:0]  r_cap_byte0;
    logic [13:0] r_cap_rev;
    logic [8:0]  r_cap_spd;
    logic [13:0] r_engine_rev;
    logic [8:0]  r_vehicle_speed;
    logic        r_eng_upd;
    logic        r_spd_upd;
    logic [7:0]  r_fmt_cnt;
    logic [7:0]  r_unk_cnt;

    logic        w_accept;
    logic        w_is_eng;
    logic        w_is_spd;
    logic        w_eng_ok;
    logic        w_spd_ok;
    logic        w_fmt_err;
    logic        w_unknown;
    logic [1:0]  w_upd;
    logic [1:0]  w_valid;
    logic        w_unused;

    assign w_accept  = stm_recv_data_in_tvalid & r_tready;
    assign w_is_eng  = r_cap_valid && (r_cap_id == ID_ENGINE_REV);
    assign w_is_spd  = r_cap_valid && (r_cap_id == ID_CAR_SPEED);
    assign w_eng_ok  = w_is_eng && (r_cap_keep == 8'hFF) && (r_cap_byte0 == 8'hFF);
    assign w_spd_ok  = w_is_spd && (r_cap_keep == 8'hFF);
    assign w_fmt_err = (w_is_eng && !w_eng_ok) || (w_is_spd && !w_spd_ok);
    assign w_unknown = r_cap_valid && !w_is_eng && !w_is_spd;
    assign w_upd     = {w_spd_ok, w_eng_ok};
    assign w_unused  = ^{stm_recv_data_in_tdata[54:48], stm_recv_data_in_tdata[33:8]};

    // Ready comes up one cycle after reset release and then never backpressures
    always_ff @(posedge clk) begin
        r_tready <= !rst;
    end

    // Stage 1: capture only the frame fields the decoder looks at
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cap_valid <= 1'b0;
            r_cap_id    <= '0;
            r_cap_keep  <= '0;
            r_cap_byte0 <= '0;
            r_cap_rev   <= '0;
            r_cap_spd   <= '0;
        end else begin
            r_cap_valid <= w_accept;
            if (w_accept) begin
                r_cap_id    <= stm_recv_data_in_tid;
                r_cap_keep  <= stm_recv_data_in_tkeep;
                r_cap_byte0 <= stm_recv_data_in_tdata[7:0];
                r_cap_rev   <= stm_recv_data_in_tdata[47:34];
                r_cap_spd   <= stm_recv_data_in_tdata[63:55];
            end
        end
    end

    // Stage 2: update values, pulse on update, count rejected and foreign frames with saturation
    always_ff @(posedge clk) begin
        if (rst) begin
            r_engine_rev    <= '0;
            r_vehicle_speed <= '0;
            r_eng_upd       <= 1'b0;
            r_spd_upd       <= 1'b0;
            r_fmt_cnt       <= '0;
            r_unk_cnt       <= '0;
        end else begin
            r_engine_rev    <= w_eng_ok ? r_cap_rev : r_engine_rev;
            r_vehicle_speed <= w_spd_ok ? r_cap_spd : r_vehicle_speed;
            r_eng_upd       <= w_eng_ok;
            r_spd_upd       <= w_spd_ok;
            r_fmt_cnt       <= (w_fmt_err && r_fmt_cnt != 8'hFF) ? r_fmt_cnt + 8'd1 : r_fmt_cnt;
            r_unk_cnt       <= (w_unknown && r_unk_cnt != 8'hFF) ? r_unk_cnt + 8'd1 : r_unk_cnt;
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_fresh
        state_t        r_state;
        logic [AW-1:0] r_age;
        logic          r_valid;

        // Freshness FSM: an update always wins over a coinciding timeout
        always_ff @(posedge clk) begin
            if (rst) begin
                r_state <= NO_DATA;
                r_age   <= '0;
                r_valid <= 1'b0;
            end else if (w_upd[g]) begin
                r_state <= FRESH;
                r_age   <= '0;
                r_valid <= 1'b1;
            end else if (r_state == FRESH && r_age == AGE_LAST) begin
                r_state <= STALE;
                r_valid <= 1'b0;
            end else if (r_state == FRESH) begin
                r_age   <= r_age + AW'(1);
            end
        end

        assign w_valid[g] = r_valid;
    end

    assign stm_recv_data_in_tready = r_tready;
    assign engine_rev              = r_engine_rev;
    assign vehicle_speed           = r_vehicle_speed;
    assign engine_rev_valid        = w_valid[0];
    assign vehicle_speed_valid     = w_valid[1];
    assign engine_rev_update       = r_eng_upd;
    assign vehicle_speed_update    = r_spd_upd;
    assign format_err_count        = r_fmt_cnt;
    assign unknown_id_count        = r_unk_cnt;
endmodule

// File: tb/tb_vehicle_data_receiver.sv
// tb_vehicle_data_receiver: randomized scoreboard bench for vehicle_data_receiver
module tb_vehicle_data_receiver;
    localparam int T = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] tdata = '0;
    logic [10:0] tid = '0;
    logic [7:0]  tkeep = '0;
    logic        tvalid = 1'b0;
    logic        tready;
    logic [13:0] engine_rev;
    logic [8:0]  vehicle_speed;
    logic        engine_rev_valid, vehicle_speed_valid;
    logic        engine_rev_update, vehicle_speed_update;
    logic [7:0]  format_err_count, unknown_id_count;

    vehicle_data_receiver #(.TIMEOUT_CYCLE(T)) dut (
        .clk(clk),
        .rst(rst),
        .stm_recv_data_in_tdata(tdata),
        .stm_recv_data_in_tid(tid),
        .stm_recv_data_in_tkeep(tkeep),
        .stm_recv_data_in_tvalid(tvalid),
        .stm_recv_data_in_tready(tready),
        .engine_rev(engine_rev),
        .vehicle_speed(vehicle_speed),
        .engine_rev_valid(engine_rev_valid),
        .vehicle_speed_valid(vehicle_speed_valid),
        .engine_rev_update(engine_rev_update),
        .vehicle_speed_update(vehicle_speed_update),
        .format_err_count(format_err_count),
        .unknown_id_count(unknown_id_count)
    );

    always #5 clk = ~clk;

    // kind: 0 engine update, 1 speed update, 2 format error, 3 unknown id
    typedef struct {
        int due;
        int kind;
        int val;
    } ev_t;

    ev_t  q[$];
    int   cyc = 0;
    logic rst_s = 1'b1;
    int   checks = 0;
    int   errors = 0;

    int m_eng = 0, m_spd = 0, m_fmt = 0, m_unk = 0;
    bit h_eng = 0, h_spd = 0;
    int l_eng = 0, l_spd = 0;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_s <= rst;
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endfunction

    function automatic ev_t classify(input logic [10:0] id, input logic [63:0] d, input logic [7:0] k, input int due);
        ev_t e;
        e.due = due;
        e.val = 0;
        if (id == 11'h3D9) begin
            e.kind = (k == 8'hFF && d[7:0] == 8'hFF) ? 0 : 2;
            e.val  = int'(d[47:34]);
        end else if (id == 11'h3E9) begin
            e.kind = (k == 8'hFF) ? 1 : 2;
            e.val  = int'(d[63:55]);
        end else begin
            e.kind = 3;
        end
        return e;
    endfunction

    // Monitor: retire due scoreboard events into the model, then compare every output
    always @(negedge clk) begin
        ev_t e;
        bit  ue, us;
        ue = 0;
        us = 0;
        if (rst_s) begin
            q.delete();
            m_eng = 0; m_spd = 0; m_fmt = 0; m_unk = 0;
            h_eng = 0; h_spd = 0;
        end
        while (q.size() > 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            case (e.kind)
                0: begin m_eng = e.val; h_eng = 1; l_eng = cyc; ue = 1; end
                1: begin m_spd = e.val; h_spd = 1; l_spd = cyc; us = 1; end
                2: m_fmt = (m_fmt < 255) ? m_fmt + 1 : 255;
                default: m_unk = (m_unk < 255) ? m_unk + 1 : 255;
            endcase
        end
        chk("tready", 32'(tready), 32'(!rst_s));
        chk("engine_rev", 32'(engine_rev), m_eng);
        chk("vehicle_speed", 32'(vehicle_speed), m_spd);
        chk("engine_rev_valid", 32'(engine_rev_valid), 32'(h_eng && (cyc - l_eng) < T));
        chk("vehicle_speed_valid", 32'(vehicle_speed_valid), 32'(h_spd && (cyc - l_spd) < T));
        chk("engine_rev_update", 32'(engine_rev_update), 32'(ue));
        chk("vehicle_speed_update", 32'(vehicle_speed_update), 32'(us));
        chk("format_err_count", 32'(format_err_count), m_fmt);
        chk("unknown_id_count", 32'(unknown_id_count), m_unk);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [10:0] id, input logic [63:0] d, input logic [7:0] k);
        int w;
        w = 0;
        while (!tready && w < 20) begin
            tick(1);
            w++;
        end
        if (!tready) begin
            checks++;
            errors++;
            $display("FAIL ready_wait: tready still 0 after %0d cycles", w);
        end
        tid = id;
        tdata = d;
        tkeep = k;
        tvalid = 1'b1;
        if (tready) q.push_back(classify(id, d, k, cyc + 2));
        tick(1);
        tvalid = 1'b0;
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    function automatic logic [10:0] rnd_unknown_id();
        logic [10:0] id;
        do id = 11'($urandom_range(0, 2047)); while (id == 11'h3D9 || id == 11'h3E9);
        return id;
    endfunction

    task automatic random_frames(input int n);
        logic [63:0] d;
        logic [7:0]  k;
        logic [10:0] id;
        int r;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 9) < 7) begin
                d = rnd64();
                if ($urandom_range(0, 4) != 0) d[7:0] = 8'hFF;
                k = ($urandom_range(0, 4) != 0) ? 8'hFF : 8'($urandom);
                r = $urandom_range(0, 3);
                id = (r == 0) ? 11'h3D9 : (r == 1) ? 11'h3E9 : rnd_unknown_id();
                send(id, d, k);
            end else begin
                tick(1);
            end
        end
    endtask

    initial begin
        logic [63:0] d;
        rst = 1'b1;
        tick(4);
        rst = 1'b0;
        tick(3);

        d = rnd64(); d[47:34] = 14'd8000; d[7:0] = 8'hFF;
        send(11'h3D9, d, 8'hFF);
        tick(3);

        d = rnd64(); d[63:55] = 9'd300;
        send(11'h3E9, d, 8'hFF);
        d = rnd64(); d[63:55] = 9'd301;
        send(11'h3E9, d, 8'hFF);
        tick(3);

        d = rnd64(); d[7:0] = 8'h00;
        send(11'h3D9, d, 8'hFF);
        d = rnd64();
        send(11'h3E9, d, 8'h0F);
        send(11'h123, rnd64(), 8'hFF);
        tick(3);
        for (int i = 0; i < 300; i++) send(rnd_unknown_id(), rnd64(), 8'($urandom));
        tick(3);

        d = rnd64(); d[63:55] = 9'd123;
        send(11'h3E9, d, 8'hFF);
        tick(T + 4);
        d = rnd64(); d[63:55] = 9'd77;
        send(11'h3E9, d, 8'hFF);
        tick(T - 1);
        d = rnd64(); d[63:55] = 9'd78;
        send(11'h3E9, d, 8'hFF);
        tick(T + 4);

        random_frames(200);
        tick(4);

        d = rnd64(); d[47:34] = 14'd1234; d[7:0] = 8'hFF;
        send(11'h3D9, d, 8'hFF);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(3);
        d = rnd64(); d[47:34] = 14'd4321; d[7:0] = 8'hFF;
        send(11'h3D9, d, 8'hFF);
        tick(4);

        random_frames(100);
        tick(T + 6);

        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d events left, expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
